// File: rtl/audio_pwm_out.sv
// audio_pwm_out
// Consumer end of the audio sample FIFO. Paces playback with a sample-rate
// pop request, captures each popped 16-bit signed sample, converts it to an
// offset-binary duty value and drives a single-bit PWM DAC pin.
//
// Parameters:
//   CLK_HZ     system clock frequency
//   SAMPLE_HZ  output sample rate; DIV = CLK_HZ / SAMPLE_HZ must be >= 4
//   PWM_BITS   PWM resolution, period = 2^PWM_BITS clocks, at most 16
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         run playback; low idles the output at mid-scale
//   mono_sample    signed sample from the FIFO, valid the cycle after a tick
//   sample_tick    one-cycle pop request to the FIFO
//   sample_strobe  one-cycle pulse when a newly captured duty takes effect
//   pwm_out        registered PWM DAC output

module audio_pwm_out #(
   parameter int CLK_HZ    = 27_000_000,
   parameter int SAMPLE_HZ = 44_100,
   parameter int PWM_BITS  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] mono_sample,
   output logic        sample_tick,
   output logic        sample_strobe,
   output logic        pwm_out
);

   localparam int DIV   = CLK_HZ / SAMPLE_HZ;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [PWM_BITS-1:0] MID      = PWM_BITS'(1) << (PWM_BITS - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

   typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

   state_t              state;
   state_t              state_next;
   logic [DIV_W-1:0]    div_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] pending;
   logic                new_flag;
   logic                capture_now;
   logic                boundary;
   logic [15:0]         offset_sample;
   logic [15:0]         shifted_sample;
   logic [PWM_BITS-1:0] conv_value;

   // Offset-binary conversion: flipping the sign bit maps the signed range
   // onto 0..FFFF, then the top PWM_BITS bits become the duty value.
   assign offset_sample  = mono_sample ^ 16'h8000;
   assign shifted_sample = offset_sample >> (16 - PWM_BITS);
   assign conv_value     = shifted_sample[PWM_BITS-1:0];

   assign sample_tick   = (div_cnt == DIV_LAST);
   assign capture_now   = (state == CAPTURE) && enable;
   assign boundary      = (pwm_cnt == PWM_MAX);
   // A strobe marks a boundary whose loaded duty is a fresh capture, either
   // one waiting in pending or one arriving in this very cycle.
   assign sample_strobe = boundary && (capture_now || new_flag);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Dropping enable always returns to IDLE, which also
   // throws away a capture that was about to happen.
   always_comb begin
      state_next = state;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = WAIT;
            WAIT:    if (sample_tick) state_next = CAPTURE;
            CAPTURE: state_next = WAIT;
            default: state_next = IDLE;
         endcase
      end
   end

   // Sample-rate divider. It is held at zero in IDLE so the first tick
   // lands exactly DIV clocks after playback is enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (!enable || state == IDLE) begin
         div_cnt <= '0;
      end else if (sample_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Pending duty and its "fresh" flag. Idle parks the next duty at
   // mid-scale with no strobe; a capture that coincides with the period
   // boundary is consumed immediately, so it does not leave the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= MID;
         new_flag <= 1'b0;
      end else if (!enable || state == IDLE) begin
         pending  <= MID;
         new_flag <= 1'b0;
      end else if (capture_now) begin
         pending  <= conv_value;
         new_flag <= !boundary;
      end else if (boundary) begin
         new_flag <= 1'b0;
      end
   end

   // Duty only changes at the end of a PWM period so no period is ever cut
   // short or stretched; a same-cycle capture bypasses pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty <= MID;
      end else if (boundary) begin
         duty <= capture_now ? conv_value : pending;
      end
   end

   // Free-running PWM counter and registered comparator output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         pwm_out <= (pwm_cnt < duty);
      end
   end

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out
// Directed self-checking bench for audio_pwm_out at default parameters
// (DIV = 612, 256-clock PWM period). The FIFO is modelled as a held value
// on mono_sample, which also covers the replay-on-empty behaviour.

module tb_audio_pwm_out;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] mono_sample = 16'h0000;
   logic        sample_tick;
   logic        sample_strobe;
   logic        pwm_out;

   int checks = 0;
   int fails  = 0;

   audio_pwm_out dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .mono_sample   (mono_sample),
      .sample_tick   (sample_tick),
      .sample_strobe (sample_strobe),
      .pwm_out       (pwm_out)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_output(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Present a new value at the FIFO output.
   task automatic apply_stimulus(input logic [15:0] s);
      mono_sample = s;
   endtask

   // Count high cycles over one full PWM period.
   task automatic measure_high(output int high);
      high = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (pwm_out) high++;
      end
   endtask

   // Wait for a tick at a negedge, bounded.
   task automatic wait_tick(input int budget, input string tag);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (sample_tick) break;
      end
      check_output(tag, int'(sample_tick), 1);
   endtask

   // Wait for a strobe at a negedge, bounded.
   task automatic wait_strobe(input int budget, input string tag);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (sample_strobe) break;
      end
      check_output(tag, int'(sample_strobe), 1);
   endtask

   // Conversion vectors with hand-computed duties.
   logic [15:0] conv_in  [4] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFF00};
   int          conv_exp [4] = '{255, 0, 128, 127};

   initial begin
      int high;
      int first_tick;
      int last_tick;
      int tick_count;
      int gap_err;
      int width_err;
      int strobe_count;
      bit prev_tick;

      // Reset and idle output at mid-scale.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      measure_high(high);
      check_output("idle_high", high, 128);

      // Asynchronous reset in the middle of a high phase.
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (pwm_out) break;
      end
      check_output("pwm_high_before_reset", int'(pwm_out), 1);
      #2 rst_n = 1'b0;
      #1 check_output("reset_pwm_out", int'(pwm_out), 0);
      check_output("reset_tick", int'(sample_tick), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Boundary coincidence: enabling when pwm_cnt is 154 puts the tick at
      // pwm_cnt 254 and CAPTURE exactly on the period boundary.
      repeat (154) @(negedge clk);
      apply_stimulus(16'h7FFF);
      enable = 1'b1;
      repeat (611) @(negedge clk);
      @(negedge clk);
      check_output("coinc_tick", int'(sample_tick), 1);
      @(negedge clk);
      check_output("coinc_strobe", int'(sample_strobe), 1);
      @(negedge clk);
      measure_high(high);
      check_output("coinc_high", high, 255);

      // Tick rate over 10 000 clocks after a fresh enable.
      enable = 1'b0;
      repeat (3) @(negedge clk);
      enable = 1'b1;
      first_tick = -1;
      last_tick  = 0;
      tick_count = 0;
      gap_err    = 0;
      width_err  = 0;
      prev_tick  = 1'b0;
      for (int i = 1; i <= 10000; i++) begin
         @(negedge clk);
         if (sample_tick) begin
            if (prev_tick) width_err++;
            if (first_tick < 0) first_tick = i;
            else if (i - last_tick != 612) gap_err++;
            last_tick = i;
            tick_count++;
         end
         prev_tick = sample_tick;
      end
      check_output("first_tick", first_tick, 612);
      check_output("tick_count", tick_count, 16);
      check_output("tick_gap_errors", gap_err, 0);
      check_output("tick_width_errors", width_err, 0);

      // Conversion of the directed sample table.
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(conv_in[k]);
         wait_tick(700, "conv_tick");
         wait_strobe(700, "conv_strobe");
         @(negedge clk);
         measure_high(high);
         check_output($sformatf("conv_high_%0d", k), high, conv_exp[k]);
      end

      // Empty FIFO: a held value is replayed, one strobe per capture.
      apply_stimulus(16'h4000);
      wait_tick(700, "empty_tick");
      tick_count   = 0;
      strobe_count = 0;
      for (int i = 0; i < 3 * 612; i++) begin
         @(negedge clk);
         if (sample_tick) tick_count++;
         if (sample_strobe) strobe_count++;
      end
      check_output("empty_ticks", tick_count, 3);
      check_output("empty_strobes", strobe_count, 3);
      wait_strobe(700, "empty_strobe");
      @(negedge clk);
      measure_high(high);
      check_output("empty_high", high, 192);

      // Enable dropped in the tick cycle: no capture, no strobe, mid-scale.
      apply_stimulus(16'h7FFF);
      wait_tick(700, "drop_pre_tick");
      wait_strobe(700, "drop_pre_strobe");
      apply_stimulus(16'h8000);
      wait_tick(700, "drop_tick");
      enable = 1'b0;
      tick_count   = 0;
      strobe_count = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (sample_tick) tick_count++;
         if (sample_strobe) strobe_count++;
      end
      check_output("drop_ticks", tick_count, 0);
      check_output("drop_strobes", strobe_count, 0);
      measure_high(high);
      check_output("drop_high", high, 128);

      // Asynchronous reset landing in a tick cycle clears the tick at once.
      enable = 1'b1;
      wait_tick(700, "reset_tick_wait");
      #2 rst_n = 1'b0;
      #1 check_output("reset_in_tick", int'(sample_tick), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
